bcd_counter_4digit: RTL and testbench
=====================================

// Module: bcd_counter_4digit
// PURPOSE
//   Four-digit BCD up/down counter for the counter lab: the stage directly upstream of the 7-segment driver.
//   count[15:0] feeds the driver's 16-bit input directly; one nibble per digit, digit 0 in [3:0].
//   Also contains: an internal prescaler that sets the count rate, a debounced clear button and a parallel load.
// PARAMETERS
//   TICK_DIV  100  clk cycles per count step (1 kHz clk -> 10 counts/s); legal range 2..65535
//   DEBOUNCE  20   consecutive stable clk cycles needed to accept a new btn_clr level; legal range 1..255
// PORTS
//   clk       in   1   system clock (1 kHz, same clock as the display driver)
//   reset     in   1   asynchronous, active-high reset
//   run       in   1   level: 1 = prescaler advances, 0 = hold (prescaler and count frozen)
//   up        in   1   direction: 1 = increment, 0 = decrement; sampled on each count step
//   btn_clr   in   1   raw, asynchronous push-button: clear request
//   load      in   1   single-cycle strobe: load load_val into count
//   load_val  in   16  four BCD digits to load
//   count     out  16  current value, four BCD digits (to display driver in[15:0])
//   tick      out  1   one-cycle pulse, registered; high in the cycle a count step takes effect
//   carry     out  1   one-cycle pulse, registered; high when a step wraps 9999->0000 (up) or 0000->9999 (down)
// BEHAVIOUR
//   Reset (async, reset=1): all registers go to zero.
//     - Outputs: count=16'h0000, tick=0, carry=0.
//     - Internal: prescaler=0, sync FFs=0, debounce counter=0, debounced level=0.
//     - Deassertion takes effect on the next clk edge.
//   Prescaler
//     - 16-bit counter, 0..TICK_DIV-1.
//     - Advances by 1 on each clk edge while run=1.
//     - At TICK_DIV-1 with run=1: wraps to 0 and a count step occurs on the same edge.
//     - run=0: prescaler holds its value; it is not cleared.
//   Count step
//     - Up: digit 0 increments; a digit going 9->0 carries into the next digit.
//     - Down: digit 0 decrements; a digit going 0->9 borrows from the next digit.
//     - tick=1 for exactly the cycle after the step edge (it coincides with the new count value).
//     - carry=1 in that same cycle only when all four digits wrap.
//   Clear path
//     - btn_clr -> 2-FF synchroniser -> debounce: an 8-bit counter counts cycles where the synced level
//       differs from the debounced level, and resets whenever they match.
//     - When the counter reaches DEBOUNCE, the debounced level takes the synced level.
//     - A rising edge of the debounced level gives a 1-cycle internal clr pulse.
//     - Latency: a clean btn_clr rise clears count at clk edge 2+DEBOUNCE+1 after the first sampling edge.
//     - Glitches shorter than DEBOUNCE cycles are ignored.
//     - Holding the button clears once; release produces no clear.
//   Load
//     - On the edge with load=1, count <= load_val.
//     - Any nibble above 9 is saturated to 9 (e.g. 16'h12FA -> 16'h1299).
//   Clear and load both
//     - force the prescaler to 0;
//     - force tick=0 and carry=0 on the following cycle.
//   Priority on one edge: clr > load > count step. The step is suppressed, but the prescaler is still
//     zeroed.
//   Changing up mid-interval takes effect on the next step; there is no glitch on count.
//   count changes only on clk edges, only by one step or by clear/load. It never holds a non-BCD nibble.
//   Reset mid-debounce discards the pending button state; a still-held button is seen as a new press only
//     after it is released and pressed again.
// TESTING
//   1. Reset, run=1, up=1, TICK_DIV=4: count steps every 4 clk; tick pulses 1 cycle per step.
//      0009 -> 0010; 0099 -> 0100.
//   2. load=1, load_val=16'h9998, up=1, run=1: count 9999, then 0000 with carry=1 and tick=1 in one cycle.
//      Then 0001 with carry=0.
//   3. load 16'h0001, up=0: 0000, then 9999 with carry=1.
//      Load 16'h1000 with up=0: next count is 0999.
//   4. load_val=16'hABCD: count=16'h9999 (saturation). run=0 for 50 cycles: count and tick frozen.
//      Raising run resumes from the held prescaler phase.
//   5. DEBOUNCE=5, btn_clr pulse of 3 cycles: no clear.
//      Press held 20 cycles: count=0000 exactly 8 edges after the press.
//      Release: no further action.
//   6. Same edge clr+load+step: count=0000, tick=0.
//      reset asserted mid-count between edges: count=0000 immediately, with no clk edge needed.

Source files
------------

// File: rtl/bcd_counter_4digit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_counter_4digit_if                                         |
// | Brief    : Control/data bundle between the counter and its controller.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface bcd_counter_4digit_if;
   logic        run;
   logic        up;
   logic        btn_clr;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        tick;
   logic        carry;

   modport master (
      output run, up, btn_clr, load, load_val,
      input  count, tick, carry
   );

   modport slave (
      input  run, up, btn_clr, load, load_val,
      output count, tick, carry
   );
endinterface
`default_nettype wire

// File: rtl/bcd_counter_4digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_counter_4digit                                            |
// | Brief    : Four-digit BCD up/down counter with prescaler, debounced      |
// |            clear button and saturating parallel load.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bcd_counter_4digit #(
   parameter int TICK_DIV = 100,
   parameter int DEBOUNCE = 20
) (
   input  wire logic             clk,
   input  wire logic             reset,
   bcd_counter_4digit_if.slave   bus
);

   localparam logic [15:0] c_PRESC_LAST = 16'(TICK_DIV - 1);
   localparam logic [7:0]  c_DB_LAST    = 8'(DEBOUNCE - 1);

   logic [15:0] r_presc;
   logic        r_sync1;
   logic        r_sync2;
   logic [7:0]  r_db_cnt;
   logic        r_db_level;
   logic        r_db_prev;
   logic [1:0]  r_fill;
   logic [7:0]  r_arm_cnt;
   logic        r_armed;
   logic [15:0] r_count;
   logic        r_tick;
   logic        r_carry;

   logic        w_step;
   logic        w_clr;
   logic        w_wrap;
   logic [15:0] w_next;

   function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[4*i +: 4] >= 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] f_bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] f_bcd_sat(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      end
      return r;
   endfunction

   assign w_step = bus.run && (r_presc == c_PRESC_LAST);
   assign w_clr  = r_db_level && !r_db_prev && r_armed;
   assign w_next = bus.up ? f_bcd_inc(r_count) : f_bcd_dec(r_count);
   assign w_wrap = bus.up ? (r_count == 16'h9999) : (r_count == 16'h0000);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_db_cnt   <= '0;
         r_db_level <= 1'b0;
         r_db_prev  <= 1'b0;
      end else begin
         r_sync1   <= bus.btn_clr;
         r_sync2   <= r_sync1;
         r_db_prev <= r_db_level;
         if (r_sync2 == r_db_level) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == c_DB_LAST) begin
            r_db_level <= r_sync2;
            r_db_cnt   <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 8'd1;
         end
      end
   end

   // After reset the clear path stays disarmed until the button has been seen
   // released (debounced and synced low) for DEBOUNCE cycles, so a button still
   // held through reset cannot masquerade as a fresh press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fill    <= '0;
         r_arm_cnt <= '0;
         r_armed   <= 1'b0;
      end else begin
         r_fill <= {r_fill[0], 1'b1};
         if (!r_armed) begin
            if (r_fill[1] && !r_sync2 && !r_db_level) begin
               if (r_arm_cnt == c_DB_LAST) begin
                  r_armed <= 1'b1;
               end else begin
                  r_arm_cnt <= r_arm_cnt + 8'd1;
               end
            end else begin
               r_arm_cnt <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
      end else if (w_clr || bus.load) begin
         r_presc <= '0;
      end else if (bus.run) begin
         r_presc <= w_step ? 16'd0 : r_presc + 16'd1;
      end
   end

   // Priority: clear, then load, then count step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
      end else begin
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
         if (w_clr) begin
            r_count <= '0;
         end else if (bus.load) begin
            r_count <= f_bcd_sat(bus.load_val);
         end else if (w_step) begin
            r_count <= w_next;
            r_tick  <= 1'b1;
            r_carry <= w_wrap;
         end
      end
   end

   assign bus.count = r_count;
   assign bus.tick  = r_tick;
   assign bus.carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_4digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bcd_counter_4digit                                         |
// | Brief    : Directed scoreboard bench for bcd_counter_4digit.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_bcd_counter_4digit;

   localparam int TICK_DIV = 4;
   localparam int DEBOUNCE = 5;

   typedef struct {
      logic [15:0] count;
      logic        carry;
      int          gap;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t sb[$];

   bcd_counter_4digit_if bus_if ();

   bcd_counter_4digit #(
      .TICK_DIV (TICK_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] c, input logic cy, input int gap);
      exp_t e;
      e.count = c;
      e.carry = cy;
      e.gap   = gap;
      sb.push_back(e);
   endtask

   // Waits for the next tick, then compares it against the oldest expectation.
   task automatic wait_step(input string tag);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus_if.tick !== 1'b1 && n < 64);
      check({tag, "_tick_seen"}, 32'(bus_if.tick), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_count"}, 32'(bus_if.count), 32'(e.count));
         check({tag, "_carry"}, 32'(bus_if.carry), 32'(e.carry));
         check({tag, "_gap"}, 32'(n), 32'(e.gap));
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      bus_if.load_val = v;
      bus_if.load     = 1'b1;
      @(negedge clk);
      bus_if.load = 1'b0;
   endtask

   initial begin
      int tick_seen;
      int changed;
      logic [15:0] held;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus_if.run      = 1'b0;
      bus_if.up       = 1'b1;
      bus_if.btn_clr  = 1'b0;
      bus_if.load     = 1'b0;
      bus_if.load_val = 16'h0000;
      repeat (2) @(negedge clk);
      check("reset_count", 32'(bus_if.count), 32'h0);
      check("reset_tick", 32'(bus_if.tick), 32'h0);
      check("reset_carry", 32'(bus_if.carry), 32'h0);
      reset = 1'b0;

      // Free run from reset: first step after TICK_DIV edges.
      bus_if.run = 1'b1;
      push(16'h0001, 1'b0, TICK_DIV);
      wait_step("run_first");
      @(negedge clk);
      check("tick_one_cycle", 32'(bus_if.tick), 32'h0);

      do_load(16'h0008);
      push(16'h0009, 1'b0, 4); push(16'h0010, 1'b0, 4);
      wait_step("d0_9"); wait_step("d0_10");
      do_load(16'h0098);
      push(16'h0099, 1'b0, 4); push(16'h0100, 1'b0, 4);
      wait_step("d1_99"); wait_step("d1_100");

      do_load(16'h9998);
      push(16'h9999, 1'b0, 4); push(16'h0000, 1'b1, 4); push(16'h0001, 1'b0, 4);
      wait_step("up_9999"); wait_step("up_wrap"); wait_step("up_0001");

      bus_if.up = 1'b0;
      do_load(16'h0001);
      push(16'h0000, 1'b0, 4); push(16'h9999, 1'b1, 4);
      wait_step("dn_0000"); wait_step("dn_wrap");
      do_load(16'h1000);
      push(16'h0999, 1'b0, 4);
      wait_step("dn_borrow");

      bus_if.up = 1'b1;
      do_load(16'hABCD);
      check("load_saturate", 32'(bus_if.count), 32'h9999);
      do_load(16'h12FA);
      check("load_saturate2", 32'(bus_if.count), 32'h1299);
      do_load(16'h9999);
      repeat (2) @(negedge clk);
      bus_if.run = 1'b0;
      held = bus_if.count;
      tick_seen = 0;
      changed = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus_if.tick === 1'b1) tick_seen++;
         if (bus_if.count !== held) changed++;
      end
      check("hold_tick", 32'(tick_seen), 32'd0);
      check("hold_count", 32'(changed), 32'd0);
      bus_if.run = 1'b1;
      push(16'h0000, 1'b1, 2);
      wait_step("resume_phase");

      // Debounced clear with the count frozen.
      bus_if.run = 1'b0;
      do_load(16'h1234);
      bus_if.btn_clr = 1'b1;
      repeat (3) @(negedge clk);
      bus_if.btn_clr = 1'b0;
      repeat (20) @(negedge clk);
      check("glitch_ignored", 32'(bus_if.count), 32'h1234);
      bus_if.btn_clr = 1'b1;
      repeat (7) @(negedge clk);
      check("clr_not_early", 32'(bus_if.count), 32'h1234);
      @(negedge clk);
      check("clr_edge8", 32'(bus_if.count), 32'h0000);
      do_load(16'h0555);
      repeat (10) @(negedge clk);
      check("held_once", 32'(bus_if.count), 32'h0555);
      bus_if.btn_clr = 1'b0;
      repeat (20) @(negedge clk);
      check("release_no_clr", 32'(bus_if.count), 32'h0555);

      // Clear, load and step all on the same edge.
      bus_if.btn_clr = 1'b1;
      repeat (4) @(negedge clk);
      bus_if.run = 1'b1;
      repeat (3) @(negedge clk);
      bus_if.load_val = 16'h4321;
      bus_if.load     = 1'b1;
      @(negedge clk);
      bus_if.load = 1'b0;
      check("prio_count", 32'(bus_if.count), 32'h0000);
      check("prio_tick", 32'(bus_if.tick), 32'h0);
      check("prio_carry", 32'(bus_if.carry), 32'h0);
      push(16'h0001, 1'b0, 4);
      wait_step("prio_presc_zeroed");

      // Asynchronous reset between edges, button still held.
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("async_reset", 32'(bus_if.count), 32'h0000);
      @(negedge clk);
      reset = 1'b0;
      bus_if.run = 1'b0;
      do_load(16'h0777);
      repeat (30) @(negedge clk);
      check("held_through_reset", 32'(bus_if.count), 32'h0777);
      bus_if.btn_clr = 1'b0;
      repeat (30) @(negedge clk);
      check("release_after_reset", 32'(bus_if.count), 32'h0777);
      bus_if.btn_clr = 1'b1;
      repeat (8) @(negedge clk);
      check("repress_clears", 32'(bus_if.count), 32'h0000);
      bus_if.btn_clr = 1'b0;

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
